// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite write front end: B-channel response codes and FSM states.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef logic [1:0] wr_state_t;

  localparam wr_state_t IDLE  = 2'd0;
  localparam wr_state_t WRITE = 2'd1;
  localparam wr_state_t RESP  = 2'd2;

endpackage

// File: rtl/axi_lite_write_ctrl.sv
// AXI4-Lite write-channel front end: captures AW and W in either order, issues one wr_en strobe, returns B.
// Build macro AXIL_RANGE_CHECK_EN: out-of-range writes get SLVERR and no wr_en strobe.
module axi_lite_write_ctrl
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data
);

`ifdef AXIL_RANGE_CHECK_EN
  localparam bit RangeCheck = 1'b1;
`else
  localparam bit RangeCheck = 1'b0;
`endif

  wr_state_t             state_q, state_d;
  logic                  ready_en_q;
  logic                  aw_full_q, aw_full_d;
  logic                  w_full_q, w_full_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  bvalid_q, bvalid_d;
  logic                  aw_hs, w_hs;
  logic                  addr_ok, write_ok;

  // ready_en_q keeps both ready outputs low for the first cycle after reset release.
  assign awready = ready_en_q && (state_q == IDLE) && !aw_full_q;
  assign wready  = ready_en_q && (state_q == IDLE) && !w_full_q;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;

  assign addr_ok  = 32'(wr_addr_q[ADDR_WIDTH-1:2]) < 32'(REG_NUM);
  assign write_ok = !RangeCheck || addr_ok;

  assign wr_en   = (state_q == WRITE) && write_ok;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign bresp   = bresp_q;
  assign bvalid  = bvalid_q;

  always_comb begin
    state_d   = state_q;
    aw_full_d = aw_full_q;
    w_full_d  = w_full_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    bresp_d   = bresp_q;
    bvalid_d  = bvalid_q;
    case (state_q)
      IDLE: begin
        if (aw_hs) begin
          wr_addr_d = awaddr;
          aw_full_d = 1'b1;
        end
        if (w_hs) begin
          wr_data_d = wdata;
          w_full_d  = 1'b1;
        end
        // The slots may fill in the same cycle or in any order.
        if (aw_full_d && w_full_d) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        aw_full_d = 1'b0;
        w_full_d  = 1'b0;
        bvalid_d  = 1'b1;
        bresp_d   = write_ok ? RESP_OKAY : RESP_SLVERR;
        state_d   = RESP;
      end
      RESP: begin
        if (bready) begin
          bvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ready_en_q <= 1'b0;
      aw_full_q  <= 1'b0;
      w_full_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      bresp_q    <= RESP_OKAY;
      bvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
      aw_full_q  <= aw_full_d;
      w_full_q   <= w_full_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      bresp_q    <= bresp_d;
      bvalid_q   <= bvalid_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_write_ctrl.sv
// Self-checking bench for axi_lite_write_ctrl: transaction-level reference model, per-cycle compare, directed and random writes.
module tb_axi_lite_write_ctrl;
  import axi_lite_pkg::*;

  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREG = 4;

`ifdef AXIL_RANGE_CHECK_EN
  localparam bit rangeCheckOn = 1'b1;
`else
  localparam bit rangeCheckOn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] awaddr = '0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [DW-1:0] wdata = '0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  int checks = 0;
  int errors = 0;
  int cycleCnt = 0;

  always #5 clk = ~clk;

  axi_lite_write_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REG_NUM(NREG)) dut (
    .clk(clk), .rst_n(rst_n),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: actual=expired required=completed at %0t", name, $time);
  endtask

  // Reference model: one outstanding write, address/data slots held as queues of at most one entry.
  bit            mReadyEn = 1'b0;
  bit            mWrite = 1'b0;
  bit            mResp = 1'b0;
  logic [AW-1:0] mAwQ[$];
  logic [DW-1:0] mWQ[$];
  logic [AW-1:0] mAddr = '0;
  logic [DW-1:0] mData = '0;
  logic [1:0]    mBresp = 2'b00;
  logic [DW-1:0] mRegs[NREG];
  logic [DW-1:0] dRegs[NREG];

  function automatic bit strobeExpected(input logic [AW-1:0] a);
    bit inRange;
    inRange = int'(a >> 2) < NREG;
    return rangeCheckOn ? inRange : 1'b1;
  endfunction

  function automatic bit expAwready();
    return mReadyEn && !mWrite && !mResp && (mAwQ.size() == 0);
  endfunction

  function automatic bit expWready();
    return mReadyEn && !mWrite && !mResp && (mWQ.size() == 0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mReadyEn = 1'b0;
      mWrite   = 1'b0;
      mResp    = 1'b0;
      mAwQ.delete();
      mWQ.delete();
      mAddr    = '0;
      mData    = '0;
      mBresp   = RESP_OKAY;
    end else begin
      bit awTaken, wTaken;
      awTaken = awvalid && expAwready();
      wTaken  = wvalid && expWready();
      if (mResp) begin
        if (bready) mResp = 1'b0;
      end else if (mWrite) begin
        if (strobeExpected(mAddr)) begin
          mBresp = RESP_OKAY;
          if (int'(mAddr >> 2) < NREG) mRegs[int'(mAddr >> 2)] = mData;
        end else begin
          mBresp = RESP_SLVERR;
        end
        mWrite = 1'b0;
        mResp  = 1'b1;
      end else begin
        if (awTaken) begin
          mAwQ.push_back(awaddr);
          mAddr = awaddr;
        end
        if (wTaken) begin
          mWQ.push_back(wdata);
          mData = wdata;
        end
        if (mAwQ.size() == 1 && mWQ.size() == 1) begin
          void'(mAwQ.pop_front());
          void'(mWQ.pop_front());
          mWrite = 1'b1;
        end
      end
      mReadyEn = 1'b1;
    end
  end

  // Per-cycle compare plus event monitor feeding the directed latency checks.
  int            wrEnCount = 0;
  int            lastWrEnCyc = 0;
  logic [AW-1:0] lastWrAddr = '0;
  logic [DW-1:0] lastWrData = '0;
  int            bRiseCyc = 0;
  logic [1:0]    bRiseResp = 2'b00;
  bit            prevBvalid = 1'b0;

  always @(negedge clk) begin
    checkOutput("awready", awready, expAwready());
    checkOutput("wready", wready, expWready());
    checkOutput("bvalid", bvalid, mResp);
    checkOutput("bresp", bresp, mBresp);
    checkOutput("wr_en", wr_en, mWrite && strobeExpected(mAddr));
    checkOutput("wr_addr", wr_addr, mAddr);
    checkOutput("wr_data", wr_data, mData);
    if (rst_n && wr_en === 1'b1) begin
      wrEnCount++;
      lastWrEnCyc = cycleCnt;
      lastWrAddr  = wr_addr;
      lastWrData  = wr_data;
      if (int'(wr_addr >> 2) < NREG) dRegs[int'(wr_addr >> 2)] = wr_data;
    end
    if (bvalid === 1'b1 && !prevBvalid) begin
      bRiseCyc  = cycleCnt;
      bRiseResp = bresp;
    end
    prevBvalid = (bvalid === 1'b1);
  end

  int tAwCyc = 0;
  int tWCyc  = 0;
  int tHsCyc = 0;
  int tBCyc  = 0;

  // One full write: AW/W asserted after their delays, bready held low for bDelay cycles of bvalid.
  task automatic applyStimulus(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                               input int awDelay, input int wDelay, input int bDelay);
    int cyc   = 0;
    int bSeen = 0;
    bit awDone = 1'b0, wDone = 1'b0, bDone = 1'b0;
    bit awHs, wHs, bHs;
    awaddr = addr;
    wdata  = data;
    while (!bDone && cyc < 300) begin
      awvalid = !awDone && (cyc >= awDelay);
      wvalid  = !wDone && (cyc >= wDelay);
      bready  = (bSeen >= bDelay);
      @(negedge clk);
      awHs = awvalid && awready;
      wHs  = wvalid && wready;
      bHs  = bvalid && bready;
      if (awHs) tAwCyc = cycleCnt;
      if (wHs) tWCyc = cycleCnt;
      if (awHs || wHs) tHsCyc = cycleCnt;
      if (bHs) tBCyc = cycleCnt;
      if (bvalid) bSeen++;
      @(posedge clk);
      #2;
      awDone = awDone || awHs;
      wDone  = wDone || wHs;
      bDone  = bHs;
      cyc++;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    if (!bDone) failNow("txn_timeout");
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  int            cnt0;
  int            wcyc[4];
  logic [DW-1:0] b2bData[4];

  initial begin
    for (int i = 0; i < NREG; i++) begin
      mRegs[i] = '0;
      dRegs[i] = '0;
    end
    repeat (3) nextCycle();
    checkOutput("reset_awready", awready, 0);
    checkOutput("reset_wready", wready, 0);
    checkOutput("reset_bvalid", bvalid, 0);
    checkOutput("reset_bresp", bresp, 0);
    checkOutput("reset_wr_en", wr_en, 0);
    checkOutput("reset_wr_addr", wr_addr, 0);
    checkOutput("reset_wr_data", wr_data, 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("ready_release_cycle", awready, 0);
    @(negedge clk);
    checkOutput("ready_one_after_release", awready, 1);
    checkOutput("wready_one_after_release", wready, 1);
    nextCycle();

    // Simultaneous AW/W, bready high.
    cnt0 = wrEnCount;
    applyStimulus(5'h04, 32'hDEADBEEF, 0, 0, 0);
    checkOutput("t1_strobe_count", wrEnCount - cnt0, 1);
    checkOutput("t1_wr_addr", lastWrAddr, 5'h04);
    checkOutput("t1_wr_data", lastWrData, 32'hDEADBEEF);
    checkOutput("t1_wr_en_latency", lastWrEnCyc - tHsCyc, 1);
    checkOutput("t1_bvalid_latency", bRiseCyc - tHsCyc, 2);
    checkOutput("t1_bresp", bRiseResp, 2'b00);
    checkOutput("t1_reg1", dRegs[1], 32'hDEADBEEF);

    // W first, AW three cycles later.
    applyStimulus(5'h08, 32'h12345678, 3, 0, 0);
    checkOutput("t2_aw_after_w", tAwCyc - tWCyc, 3);
    checkOutput("t2_wr_en_latency", lastWrEnCyc - tAwCyc, 1);
    checkOutput("t2_wr_addr", lastWrAddr, 5'h08);
    checkOutput("t2_reg2", dRegs[2], 32'h12345678);

    // B backpressure for 10 cycles.
    applyStimulus(5'h0C, 32'hCAFEF00D, 0, 0, 10);
    checkOutput("t3_b_held", tBCyc - bRiseCyc, 10);
    @(negedge clk);
    checkOutput("t3_idle_after_b", awready, 1);
    nextCycle();

    // Out-of-range address.
    cnt0 = wrEnCount;
    applyStimulus(5'h10, 32'hA5A5A5A5, 0, 0, 0);
    checkOutput("t4_strobe_count", wrEnCount - cnt0, rangeCheckOn ? 0 : 1);
    checkOutput("t4_bresp", bRiseResp, rangeCheckOn ? 2'b10 : 2'b00);

    // Back-to-back writes at minimum spacing.
    for (int i = 0; i < 4; i++) begin
      b2bData[i] = 32'hB0000000 + 32'(i * 17);
      applyStimulus(AW'(i * 4), b2bData[i], 0, 0, 0);
      wcyc[i] = lastWrEnCyc;
    end
    for (int i = 1; i < 4; i++) checkOutput("t5_spacing", wcyc[i] - wcyc[i-1], 3);
    for (int i = 0; i < 4; i++) checkOutput("t5_reg", dRegs[i], b2bData[i]);

    // Reset while holding the B response.
    awaddr = 5'h04; wdata = 32'h55AA55AA;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    nextCycle();
    awvalid = 1'b0; wvalid = 1'b0;
    repeat (2) nextCycle();
    checkOutput("t6_in_resp", bvalid, 1);
    cnt0 = wrEnCount;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_bvalid", bvalid, 0);
    checkOutput("t6_rst_wr_addr", wr_addr, 0);
    checkOutput("t6_rst_wr_data", wr_data, 0);
    checkOutput("t6_rst_awready", awready, 0);
    repeat (2) nextCycle();
    rst_n = 1'b1;
    nextCycle();
    checkOutput("t6_no_new_strobe", wrEnCount - cnt0, 0);

    // Reset after only AW captured; the stale address slot must not survive.
    awaddr = 5'h0C; awvalid = 1'b1;
    nextCycle();
    awvalid = 1'b0;
    nextCycle();
    rst_n = 1'b0;
    nextCycle();
    rst_n = 1'b1;
    nextCycle();
    cnt0 = wrEnCount;
    wdata = 32'h0BADF00D; wvalid = 1'b1;
    nextCycle();
    wvalid = 1'b0;
    repeat (5) nextCycle();
    checkOutput("t7_no_strobe_w_only", wrEnCount - cnt0, 0);
    applyStimulus(5'h00, 32'hFFFFFFFF, 0, 1000, 0);
    checkOutput("t7_strobe_count", wrEnCount - cnt0, 1);
    checkOutput("t7_wr_addr", lastWrAddr, 5'h00);
    checkOutput("t7_wr_data", lastWrData, 32'h0BADF00D);

    // Randomized traffic checked cycle by cycle against the model.
    for (int n = 0; n < 80; n++) begin
      int gap;
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        awaddr = AW'($urandom);
        wdata  = $urandom;
        nextCycle();
      end
      applyStimulus(AW'($urandom_range(0, 31)), $urandom, $urandom_range(0, 4),
                    $urandom_range(0, 4), $urandom_range(0, 3));
    end
    repeat (2) nextCycle();
    for (int i = 0; i < NREG; i++) checkOutput("final_reg", dRegs[i], mRegs[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
